sram_burst_writer: RTL and testbench

//  Write-side master for the single-port SRAM interface (sram_intf: clk, rst, wren, addr, d_in).
//  - Accepts one burst command: start address + length.
//  - Streams the data beats over a valid/ready handshake into consecutive SRAM locations.
//  - Drives wren/addr/d_in from registers. Holds wren low whenever it is not writing, so
//    the interface is left in read mode for the read path.

---
 rtl/sram_burst_writer.sv | 133 +++++++++++++
 tb/tb_sram_burst_writer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_writer.sv
// rtl/sram_burst_writer.sv - burst write master for a single-port SRAM (command + beat stream in, wren/addr/d_in out)
// Optional abort/aborted ports are built when SRAM_WR_ABORT_EN is defined.
module sram_burst_writer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              wren,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] d_in,
  output logic              busy,
  output logic              done
`ifdef SRAM_WR_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   left;
  logic              cmd_fire;
  logic              beat_fire;
  logic              beat_write;
  logic              last_beat;
  logic              abort_hit;

`ifdef SRAM_WR_ABORT_EN
  assign abort_hit = (state == S_BURST) && abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign beat_fire  = wdata_valid && wdata_ready;
  // A beat that handshakes on the abort edge is dropped, never written.
  assign beat_write = beat_fire && !abort_hit;
  assign last_beat  = beat_write && (left == (ADDR_W+1)'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (abort_hit) begin
          state_nxt = S_IDLE;
        end else if (last_beat) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Handshake readies are masked by reset so nothing is accepted while held.
  always_comb begin
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    busy        = 1'b0;
    if (rst) begin
      cmd_ready   = (state == S_IDLE);
      wdata_ready = (state == S_BURST);
    end
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wren     <= 1'b0;
      addr     <= '0;
      d_in     <= '0;
      done     <= 1'b0;
      cur_addr <= '0;
      left     <= '0;
    end else begin
      wren <= beat_write;
      done <= last_beat;
      if (cmd_fire) begin
        cur_addr <= cmd_addr;
        left     <= {1'b0, cmd_len} + (ADDR_W+1)'(1);
      end else if (beat_write) begin
        addr     <= cur_addr;
        d_in     <= wdata;
        cur_addr <= cur_addr + ADDR_W'(1);
        left     <= left - (ADDR_W+1)'(1);
      end
    end
  end

`ifdef SRAM_WR_ABORT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      aborted <= 1'b0;
    end else begin
      aborted <= abort_hit;
    end
  end
`endif

endmodule

// File: tb/tb_sram_burst_writer.sv
// tb/tb_sram_burst_writer.sv - directed and randomized bursts checked against a cycle-level write model
module tb_sram_burst_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       wdata_valid = 1'b0;
  logic [3:0] cmd_addr = 4'd0;
  logic [3:0] cmd_len = 4'd0;
  logic [7:0] wdata = 8'd0;
  logic       cmd_ready, wdata_ready, wren, busy, done;
  logic [3:0] addr;
  logic [7:0] d_in;
`ifdef SRAM_WR_ABORT_EN
  logic       abort = 1'b0;
  logic       aborted;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic mon_en = 1'b0;

  // Expected SRAM-side outputs for the current cycle, and what the stimulus predicts for the next.
  logic       exp_wren = 1'b0, exp_done = 1'b0;
  logic [3:0] exp_a = 4'd0;
  logic [7:0] exp_d = 8'd0;
  logic       nxt_wren = 1'b0, nxt_done = 1'b0;
  logic [3:0] nxt_a = 4'd0;
  logic [7:0] nxt_d = 8'd0;
  logic [7:0] bdat [16];

  sram_burst_writer #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .wren(wren), .addr(addr), .d_in(d_in), .busy(busy), .done(done)
`ifdef SRAM_WR_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("wren", 32'(wren), 32'(exp_wren));
      chk("done", 32'(done), 32'(exp_done));
      chk("addr", 32'(addr), 32'(exp_a));
      chk("d_in", 32'(d_in), 32'(exp_d));
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    exp_wren = nxt_wren;
    exp_done = nxt_done;
    if (!r) begin
      exp_wren = 1'b0;
      exp_done = 1'b0;
      exp_a    = 4'd0;
      exp_d    = 8'd0;
    end else if (nxt_wren) begin
      exp_a = nxt_a;
      exp_d = nxt_d;
    end
    nxt_wren = 1'b0;
    nxt_done = 1'b0;
  endtask

  // mode 0: valid held high, 1: valid pattern 1,0,0 repeating, 2: random valid.
  task automatic burst(input logic [3:0] a, input logic [3:0] l, input int mode,
                       input int rst_at, input int abort_at);
    int   n;
    int   i;
    int   guard;
    int   t0;
    int   dc0;
    logic v;
    logic [3:0] ca;
    n = int'(l) + 1;
    i = 0;
    guard = 0;
    ca = a;
    dc0 = done_cnt;
    cmd_addr = a;
    cmd_len = l;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    t0 = cyc;
    tick();
    cmd_valid = 1'b0;
    while (i < n && guard < 300) begin
      if (i == rst_at) begin
        wdata_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_wdata_ready", 32'(wdata_ready), 0);
        rst = 1'b1;
        tick();
        chk("rst_no_done", 32'(done_cnt - dc0), 0);
        return;
      end
      case (mode)
        0: v = 1'b1;
        1: v = (guard % 3 == 0);
        default: v = 1'($urandom % 2);
      endcase
      wdata_valid = v;
      wdata = bdat[i];
      chk("wdata_ready_burst", 32'(wdata_ready), 1);
      chk("cmd_ready_burst", 32'(cmd_ready), 0);
      chk("busy_burst", 32'(busy), 1);
`ifdef SRAM_WR_ABORT_EN
      if (i == abort_at) begin
        wdata_valid = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wdata_valid = 1'b0;
        chk("aborted_pulse", 32'(aborted), 1);
        chk("abort_cmd_ready", 32'(cmd_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        tick();
        chk("aborted_clear", 32'(aborted), 0);
        chk("abort_no_done", 32'(done_cnt - dc0), 0);
        return;
      end
`endif
      if (v) begin
        nxt_wren = 1'b1;
        nxt_a = ca;
        nxt_d = bdat[i];
        nxt_done = (i == n - 1);
      end
      tick();
      if (v) begin
        i++;
        ca = ca + 4'd1;
      end
      guard++;
    end
    wdata_valid = 1'b0;
    chk("beats_accepted", i, n);
    chk("done_state_busy", 32'(busy), 1);
    chk("done_state_cmd_ready", 32'(cmd_ready), 0);
    chk("done_state_wdata_ready", 32'(wdata_ready), 0);
    tick();
    chk("idle_cmd_ready", 32'(cmd_ready), 1);
    chk("idle_busy", 32'(busy), 0);
    chk("done_count", done_cnt - dc0, 1);
    if (mode == 0) chk("burst_latency", cyc - t0, n + 2);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) bdat[k] = 8'($urandom);

    // 1. reset
    tick();
    mon_en = 1'b1;
    tick();
    chk("rst_held_cmd_ready", 32'(cmd_ready), 0);
    rst = 1'b1;
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 1);
    chk("reset_wdata_ready", 32'(wdata_ready), 0);
    chk("reset_busy", 32'(busy), 0);

    // wdata_valid while idle must not produce a write
    wdata_valid = 1'b1;
    wdata = 8'h5A;
    tick();
    tick();
    wdata_valid = 1'b0;

    // 2. back-to-back burst A1..D4 at 3
    bdat[0] = 8'hA1; bdat[1] = 8'hB2; bdat[2] = 8'hC3; bdat[3] = 8'hD4;
    burst(4'd3, 4'd3, 0, -1, -1);

    // 3. wrap-around
    burst(4'd14, 4'd3, 0, -1, -1);

    // 4. gapped valid
    bdat[0] = 8'hA1; bdat[1] = 8'hB2; bdat[2] = 8'hC3; bdat[3] = 8'hD4;
    burst(4'd3, 4'd3, 1, -1, -1);

    // 5. reset after the second beat, then a fresh command
    burst(4'd2, 4'd3, 0, 2, -1);
    burst(4'd9, 4'd0, 0, -1, -1);

`ifdef SRAM_WR_ABORT_EN
    // 6. abort together with the second beat
    burst(4'd8, 4'd3, 0, -1, 1);
    burst(4'd5, 4'd1, 0, -1, -1);
`endif

    // full-memory burst and randomized bursts
    for (int k = 0; k < 16; k++) bdat[k] = 8'($urandom);
    burst(4'd7, 4'd15, 0, -1, -1);
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 16; k++) bdat[k] = 8'($urandom);
      burst(4'($urandom), 4'($urandom), $urandom_range(0, 2), -1, -1);
    end

    tick();
    tick();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
